tcp_s2m_dma: RTL and testbench

Stream-to-memory DMA for the network processor receive path. Consumes the 8-bit AXI-Stream packet produced by the per-stream RX arbiter (s2m_rx_axis) and packs bytes little-endian into 32-bit words. Writes the words to a word-aligned buffer through an AXI4-Lite master. Reports packet length, destination and error status to the TCP register block. It is the inverse of the m2s path that feeds the TX demux.

---
 rtl/tcp_s2m_dma.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tcp_s2m_dma.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_s2m_dma.sv
// -----------------------------------------------------------------------------
// tcp_s2m_dma
//
// Receive-path stream-to-memory DMA. Bytes arriving on an 8-bit AXI-Stream are
// packed little-endian into 32-bit words and written to a word-aligned buffer
// through an AXI4-Lite master (write channels only, one write outstanding).
// Once a packet has been fully consumed, the block reports its length,
// destination and error status.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   s_axis_*              input byte stream (tdest sampled on the first byte,
//                         tuser sampled on the tlast byte)
//   i_start               arm for one packet (only honoured while idle)
//   i_base_addr           buffer base address (bits [1:0] forced to zero)
//   i_max_len             buffer capacity in bytes
//   o_busy / o_done       armed-or-transferring flag / completion pulse
//   o_len, o_dest         bytes written to memory, tdest of the packet
//   o_overflow            bytes were discarded past the capacity
//   o_user_err            tuser was set on the last byte
//   o_bus_err             some write response was not OKAY
//   m_axil_aw*/w*/b*      AXI4-Lite write master
// -----------------------------------------------------------------------------
module tcp_s2m_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int DEST_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic                  s_axis_tuser,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_max_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_WIDTH-1:0]  o_len,
    output logic [DEST_WIDTH-1:0] o_dest,
    output logic                  o_overflow,
    output logic                  o_user_err,
    output logic                  o_bus_err,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    input  logic [1:0]            m_axil_bresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_RESP,
        S_DROP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  max_q, max_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic [31:0]           word_q, word_d;
    logic [3:0]            strb_q, strb_d;
    logic [1:0]            lane_q, lane_d;
    logic                  last_q, last_d;     // tlast already consumed
    logic                  cap_q, cap_d;       // capacity hit before tlast
    logic                  first_q, first_d;   // next accepted byte is the first
    logic                  issued_q, issued_d; // valids raised for this word
    logic                  awv_q, awv_d;
    logic                  wv_q, wv_d;
    logic                  ovf_q, ovf_d;
    logic                  uerr_q, uerr_d;
    logic                  berr_q, berr_d;

    logic [LEN_WIDTH-1:0]  len_inc;

    assign len_inc = len_q + LEN_WIDTH'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            max_q    <= '0;
            len_q    <= '0;
            dest_q   <= '0;
            word_q   <= '0;
            strb_q   <= '0;
            lane_q   <= '0;
            last_q   <= 1'b0;
            cap_q    <= 1'b0;
            first_q  <= 1'b0;
            issued_q <= 1'b0;
            awv_q    <= 1'b0;
            wv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            uerr_q   <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            max_q    <= max_d;
            len_q    <= len_d;
            dest_q   <= dest_d;
            word_q   <= word_d;
            strb_q   <= strb_d;
            lane_q   <= lane_d;
            last_q   <= last_d;
            cap_q    <= cap_d;
            first_q  <= first_d;
            issued_q <= issued_d;
            awv_q    <= awv_d;
            wv_q     <= wv_d;
            ovf_q    <= ovf_d;
            uerr_q   <= uerr_d;
            berr_q   <= berr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        max_d         = max_q;
        len_d         = len_q;
        dest_d        = dest_q;
        word_d        = word_q;
        strb_d        = strb_q;
        lane_d        = lane_q;
        last_d        = last_q;
        cap_d         = cap_q;
        first_d       = first_q;
        issued_d      = issued_q;
        awv_d         = awv_q;
        wv_d          = wv_q;
        ovf_d         = ovf_q;
        uerr_d        = uerr_q;
        berr_d        = berr_q;
        s_axis_tready = 1'b0;
        m_axil_bready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr & ~ADDR_WIDTH'(3);
                    max_d   = i_max_len;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    uerr_d  = 1'b0;
                    berr_d  = 1'b0;
                    word_d  = '0;
                    strb_d  = '0;
                    lane_d  = '0;
                    last_d  = 1'b0;
                    cap_d   = 1'b0;
                    first_d = 1'b1;
                    state_d = S_RECV;
                end
            end

            S_RECV: begin
                // A zero-capacity buffer never stores anything: discard the
                // whole packet without taking a byte here.
                if (max_q == '0) begin
                    state_d = S_DROP;
                end else begin
                    s_axis_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        word_d[{lane_q, 3'b000} +: 8] = s_axis_tdata;
                        strb_d[lane_q] = 1'b1;
                        lane_d = lane_q + 2'd1;
                        len_d  = len_inc;
                        if (first_q) begin
                            dest_d  = s_axis_tdest;
                            first_d = 1'b0;
                        end
                        if (s_axis_tlast) begin
                            last_d = 1'b1;
                            uerr_d = s_axis_tuser;
                        end
                        if (lane_q == 2'd3 || s_axis_tlast || len_inc == max_q) begin
                            cap_d   = !s_axis_tlast && (len_inc == max_q);
                            state_d = S_WRITE;
                        end
                    end
                end
            end

            S_WRITE: begin
                // First cycle raises both valids; afterwards each drops on its
                // own handshake and we leave once neither is still pending.
                if (!issued_q) begin
                    issued_d = 1'b1;
                    awv_d    = 1'b1;
                    wv_d     = 1'b1;
                end else begin
                    if (awv_q && m_axil_awready) awv_d = 1'b0;
                    if (wv_q && m_axil_wready)   wv_d  = 1'b0;
                    if ((!awv_q || m_axil_awready) && (!wv_q || m_axil_wready)) begin
                        issued_d = 1'b0;
                        state_d  = S_RESP;
                    end
                end
            end

            S_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != 2'b00) berr_d = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(4);
                    word_d = '0;
                    strb_d = '0;
                    lane_d = '0;
                    if (last_q)     state_d = S_DONE;
                    else if (cap_q) state_d = S_DROP;
                    else            state_d = S_RECV;
                end
            end

            S_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    ovf_d = 1'b1;
                    if (first_q) begin
                        dest_d  = s_axis_tdest;
                        first_d = 1'b0;
                    end
                    if (s_axis_tlast) begin
                        uerr_d  = s_axis_tuser;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done         = (state_q == S_DONE);
    assign o_len          = len_q;
    assign o_dest         = dest_q;
    assign o_overflow     = ovf_q;
    assign o_user_err     = uerr_q;
    assign o_bus_err      = berr_q;
    assign m_axil_awvalid = awv_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_wvalid  = wv_q;
    assign m_axil_wdata   = word_q;
    assign m_axil_wstrb   = strb_q;

endmodule

// File: tb/tb_tcp_s2m_dma.sv
// -----------------------------------------------------------------------------
// Testbench for tcp_s2m_dma: directed packets from the test plan followed by
// randomised packets, all compared against a packet-level reference model
// (bytes kept = min(length, capacity), chunked into 4-byte words).
// -----------------------------------------------------------------------------
module tb_tcp_s2m_dma;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdest = '0;
    logic          s_axis_tuser = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [LW-1:0] i_max_len = '0;
    logic          o_busy, o_done, o_overflow, o_user_err, o_bus_err;
    logic [LW-1:0] o_len;
    logic [DW-1:0] o_dest;
    logic          m_axil_awvalid;
    logic          m_axil_awready = 1'b0;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_wvalid;
    logic          m_axil_wready = 1'b0;
    logic [31:0]   m_axil_wdata;
    logic [3:0]    m_axil_wstrb;
    logic          m_axil_bvalid = 1'b0;
    logic          m_axil_bready;
    logic [1:0]    m_axil_bresp = 2'b00;

    always #5 clk = ~clk;

    tcp_s2m_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEST_WIDTH(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
        .i_start(i_start), .i_base_addr(i_base_addr), .i_max_len(i_max_len),
        .o_busy(o_busy), .o_done(o_done), .o_len(o_len), .o_dest(o_dest),
        .o_overflow(o_overflow), .o_user_err(o_user_err), .o_bus_err(o_bus_err),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_bresp(m_axil_bresp)
    );

    int checks = 0;
    int fails  = 0;

    // Memory-side responder configuration and observations.
    int aw_dly = 0, w_dly = 0, b_dly = 0, err_idx = 99;
    int aw_wait = 0, w_wait = 0, b_wait = 0, b_idx = 0;
    int aw_hi = 0, w_hi = 0, stab_err = 0, trdy_err = 0, done_cnt = 0;
    logic          busy_at_done = 1'b0;
    logic [AW-1:0] aw_log[$];
    logic [35:0]   w_log[$];
    logic          prev_awv = 1'b0, prev_wv = 1'b0;
    logic [AW-1:0] prev_awaddr = '0;
    logic [35:0]   prev_w = '0;
    logic [7:0]    pkt[0:31];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
            $error("%s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // AXI-Lite slave: readies/bvalid are decided on the falling edge for the
    // following rising edge, so handshakes are logged here as well.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axil_awvalid) begin
                m_axil_awready = (aw_wait >= aw_dly);
                aw_wait++;
                aw_hi++;
            end else begin
                m_axil_awready = 1'b0;
                aw_wait = 0;
            end
            if (m_axil_wvalid) begin
                m_axil_wready = (w_wait >= w_dly);
                w_wait++;
                w_hi++;
            end else begin
                m_axil_wready = 1'b0;
                w_wait = 0;
            end
            if (m_axil_bready) begin
                if (b_wait >= b_dly) begin
                    m_axil_bvalid = 1'b1;
                    m_axil_bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
                end else begin
                    m_axil_bvalid = 1'b0;
                    m_axil_bresp  = 2'b00;
                end
                b_wait++;
            end else begin
                m_axil_bvalid = 1'b0;
                m_axil_bresp  = 2'b00;
                b_wait = 0;
            end
            if (m_axil_awvalid && m_axil_awready) aw_log.push_back(m_axil_awaddr);
            if (m_axil_wvalid && m_axil_wready) w_log.push_back({m_axil_wstrb, m_axil_wdata});
            if (m_axil_bvalid && m_axil_bready) b_idx++;
            if (m_axil_awvalid && prev_awv && m_axil_awaddr !== prev_awaddr) stab_err++;
            if (m_axil_wvalid && prev_wv && {m_axil_wstrb, m_axil_wdata} !== prev_w) stab_err++;
            prev_awv    = m_axil_awvalid && !m_axil_awready;
            prev_wv     = m_axil_wvalid && !m_axil_wready;
            prev_awaddr = m_axil_awaddr;
            prev_w      = {m_axil_wstrb, m_axil_wdata};
            if (s_axis_tready && (m_axil_awvalid || m_axil_wvalid || m_axil_bready)) trdy_err++;
            if (m_axil_awprot != 3'b000) stab_err++;
            if (o_done) begin
                done_cnt++;
                busy_at_done = o_busy;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic send_pkt(input int n, input logic [DW-1:0] dest, input logic user);
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_axis_tdata  = pkt[i];
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (i == n - 1);
            s_axis_tuser  = (i == n - 1) ? user : 1'($urandom);
            s_axis_tdest  = (i == 0) ? dest : 8'($urandom);
            g = 0;
            while (!s_axis_tready && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) begin
                check("tready_timeout", 64'(g < 200), 64'(1));
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic run_pkt(input string nm, input logic [AW-1:0] base, input int mx,
                           input int n, input logic [DW-1:0] dest, input logic user,
                           input bit mid_start);
        int g, acc, nw;
        logic [AW-1:0] ea;
        logic [31:0]   ed;
        logic [3:0]    es;
        aw_log.delete();
        w_log.delete();
        b_idx = 0; done_cnt = 0; aw_hi = 0; w_hi = 0; stab_err = 0; trdy_err = 0;
        @(negedge clk);
        i_base_addr = base;
        i_max_len   = LW'(mx);
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check({nm, "_busy"}, 64'(o_busy), 64'(1));
        send_pkt(n, dest, user);
        if (mid_start) begin
            i_start     = 1'b1;
            i_base_addr = 32'h3000;
            i_max_len   = 16'd64;
            @(negedge clk);
            i_start = 1'b0;
        end
        g = 0;
        while (done_cnt == 0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);

        acc = (n < mx) ? n : mx;
        nw  = (acc + 3) / 4;
        check({nm, "_aw_count"}, 64'(aw_log.size()), 64'(nw));
        check({nm, "_w_count"}, 64'(w_log.size()), 64'(nw));
        for (int k = 0; k < nw && k < aw_log.size() && k < w_log.size(); k++) begin
            ed = '0;
            es = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < acc) begin
                    ed[8*j +: 8] = pkt[4*k+j];
                    es[j] = 1'b1;
                end
            end
            ea = (base & ~32'h3) + AW'(4 * k);
            check({nm, "_awaddr"}, 64'(aw_log[k]), 64'(ea));
            check({nm, "_wdata"}, 64'(w_log[k][31:0]), 64'(ed));
            check({nm, "_wstrb"}, 64'(w_log[k][35:32]), 64'(es));
        end
        check({nm, "_len"}, 64'(o_len), 64'(acc));
        check({nm, "_dest"}, 64'(o_dest), 64'(dest));
        check({nm, "_overflow"}, 64'(o_overflow), 64'(n > mx));
        check({nm, "_user_err"}, 64'(o_user_err), 64'(user));
        check({nm, "_bus_err"}, 64'(o_bus_err), 64'(err_idx < nw));
        check({nm, "_done_pulses"}, 64'(done_cnt), 64'(1));
        check({nm, "_busy_at_done"}, 64'(busy_at_done), 64'(0));
        check({nm, "_stable"}, 64'(stab_err), 64'(0));
        check({nm, "_tready_in_write"}, 64'(trdy_err), 64'(0));
    endtask

    initial begin
        int n, mx, g;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({m_axil_awvalid, m_axil_wvalid, s_axis_tready, m_axil_bready, o_busy,
                   o_done, o_len, o_dest, o_overflow, o_user_err, o_bus_err}), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-word packet
        for (int i = 0; i < 6; i++) pkt[i] = 8'(i + 1);
        run_pkt("basic", 32'h1000, 64, 6, 8'd3, 1'b0, 1'b0);

        // Backpressure on AW and B
        aw_dly = 3; w_dly = 0; b_dly = 2;
        for (int i = 0; i < 4; i++) pkt[i] = 8'(8'hA0 + i);
        run_pkt("backpressure", 32'h40, 64, 4, 8'd7, 1'b0, 1'b0);
        check("bp_awvalid_cycles", 64'(aw_hi), 64'(4));
        check("bp_wvalid_cycles", 64'(w_hi), 64'(1));
        aw_dly = 0; b_dly = 0;

        // Overflow past capacity
        for (int i = 0; i < 10; i++) pkt[i] = 8'(8'h10 + i);
        run_pkt("overflow", 32'h0, 5, 10, 8'd1, 1'b0, 1'b0);

        // Bus error on the second of three writes, tuser on tlast
        err_idx = 1;
        for (int i = 0; i < 9; i++) pkt[i] = 8'(8'h30 + i);
        run_pkt("errors", 32'h500, 64, 9, 8'd9, 1'b1, 1'b0);
        err_idx = 99;

        // Single byte at an unaligned base, with a stray start mid-transfer
        pkt[0] = 8'hAB;
        run_pkt("one_byte", 32'h2003, 64, 1, 8'd5, 1'b0, 1'b1);

        // Zero capacity
        for (int i = 0; i < 3; i++) pkt[i] = 8'(8'h55 + i);
        run_pkt("max_zero", 32'h800, 0, 3, 8'd2, 1'b0, 1'b0);

        // Randomised packets
        for (int r = 0; r < 8; r++) begin
            n  = 1 + int'($urandom % 12);
            mx = int'($urandom % 15);
            for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
            aw_dly  = int'($urandom % 3);
            w_dly   = int'($urandom % 3);
            b_dly   = int'($urandom % 3);
            err_idx = int'($urandom % 5);
            run_pkt($sformatf("rand%0d", r), 32'($urandom), mx, n, 8'($urandom),
                    1'($urandom), 1'b0);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; err_idx = 99;

        // Reset while a write is pending on AW
        aw_dly = 20;
        @(negedge clk);
        i_base_addr = 32'h200;
        i_max_len   = 16'd64;
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 4; i++) pkt[i] = 8'(8'hC0 + i);
        send_pkt(4, 8'd4, 1'b0);
        g = 0;
        while (!m_axil_awvalid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("rst_mid_awvalid_seen", 64'(m_axil_awvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              64'({m_axil_awvalid, m_axil_wvalid, s_axis_tready, o_busy, o_done, o_len,
                   o_dest, o_overflow, o_user_err, o_bus_err}), 64'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        aw_dly = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) pkt[i] = 8'(8'hD0 + i);
        run_pkt("post_reset", 32'h100, 64, 4, 8'd6, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
